// File: rtl/tc_serial_ctrl_pkg.sv
// rtl/tc_serial_ctrl_pkg.sv - shared state encodings, byte width and index sizing for the serial negator
package tc_serial_ctrl_pkg;

    localparam int TC_BYTE_W = 8;

    typedef enum logic [1:0] {
        TC_IDLE = 2'd0,
        TC_RUN  = 2'd1,
        TC_DONE = 2'd2
    } tc_state_e;

    // Byte index needs at least one bit even for a single-byte operand.
    function automatic int tc_idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/tc_byte_stage.sv
// rtl/tc_byte_stage.sv - combinational 8-bit invert-plus-carry stage (NOT8 feeding a half-adder chain)
module tc_byte_stage
    import tc_serial_ctrl_pkg::*;
(
    input  logic [TC_BYTE_W-1:0] b,
    input  logic                 cin,
    output logic [TC_BYTE_W-1:0] out,
    output logic                 cout
);

    logic [TC_BYTE_W-1:0] nb;
    logic [TC_BYTE_W:0]   c;

    assign nb   = ~b;
    assign c[0] = cin;

    for (genvar i = 0; i < TC_BYTE_W; i++) begin : g_ha
        assign out[i]  = nb[i] ^ c[i];
        assign c[i+1]  = nb[i] & c[i];
    end

    assign cout = c[TC_BYTE_W];

endmodule

// File: rtl/tc_serial_ctrl.sv
// rtl/tc_serial_ctrl.sv - byte-serial two's-complement negation controller; optional TC_OVF_EN adds ovf
module tc_serial_ctrl
    import tc_serial_ctrl_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [TC_BYTE_W*NBYTES-1:0] operand,
    output logic                        busy,
    output logic                        done,
`ifdef TC_OVF_EN
    output logic                        ovf,
`endif
    output logic [TC_BYTE_W*NBYTES-1:0] result
);

    localparam int W     = TC_BYTE_W * NBYTES;
    localparam int IDX_W = tc_idx_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    tc_state_e            state_q, state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [W-1:0]         sreg_q;
    logic                 carry_q;
    logic [W-1:0]         result_q;
    logic [TC_BYTE_W-1:0] stage_out;
    logic                 stage_cout;
    logic                 last_byte;
    logic                 accept;

    assign last_byte = (idx_q == LAST_IDX);
    assign accept    = start && (state_q == TC_IDLE || state_q == TC_DONE);

    tc_byte_stage u_stage (
        .b    (sreg_q[TC_BYTE_W-1:0]),
        .cin  (carry_q),
        .out  (stage_out),
        .cout (stage_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TC_IDLE: if (start) state_d = TC_RUN;
            TC_RUN:  if (last_byte) state_d = TC_DONE;
            TC_DONE: state_d = start ? TC_RUN : TC_IDLE;
            default: state_d = TC_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == TC_RUN);
        done = (state_q == TC_DONE);
    end

    // The current byte always sits in the low lane of the shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q   <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b1;
            result_q <= '0;
        end else if (accept) begin
            sreg_q  <= operand;
            idx_q   <= '0;
            carry_q <= 1'b1;
        end else if (state_q == TC_RUN) begin
            sreg_q <= sreg_q >> TC_BYTE_W;
            result_q[idx_q*TC_BYTE_W +: TC_BYTE_W] <= stage_out;
            carry_q <= stage_cout;
            if (!last_byte) idx_q <= idx_q + 1'b1;
        end
    end

    assign result = result_q;

`ifdef TC_OVF_EN
    logic ovf_q;

    // Most-negative input: MSB byte 0x80 with all lower bytes zero (carry still set).
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            ovf_q <= 1'b0;
        end else if (state_q == TC_RUN && last_byte && carry_q
                     && sreg_q[TC_BYTE_W-1:0] == 8'h80) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_tc_serial_ctrl.sv
// tb/tb_tc_serial_ctrl.sv - self-checking bench for tc_serial_ctrl with NBYTES=4
module tb_tc_serial_ctrl;

    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   operand;
    logic          busy;
    logic          done;
    logic [31:0]   result;
`ifdef TC_OVF_EN
    logic          ovf;
`endif

    int total = 0;
    int bad   = 0;

    tc_serial_ctrl #(.NBYTES(NB)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .operand (operand),
        .busy    (busy),
        .done    (done),
`ifdef TC_OVF_EN
        .ovf     (ovf),
`endif
        .result  (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [31:0] model_neg(input logic [31:0] op);
        logic [32:0] m;
        m = 33'h1_0000_0000 - {1'b0, op};
        return m[31:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] op, input logic [31:0] exp, input logic exp_ovf);
        int n;
        int bc;
        @(negedge clk);
        start   = 1'b1;
        operand = op;
        @(posedge clk);
        #1;
        start = 1'b0;
        n  = 0;
        bc = busy ? 1 : 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) bc++;
        end
        chk("latency", 64'(n), 64'(NB));
        chk("busy_cycles", 64'(bc), 64'(NB));
        chk("result", 64'(result), 64'(exp));
`ifdef TC_OVF_EN
        chk("ovf", 64'(ovf), 64'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("note: ovf expectation unknown");
`endif
        @(posedge clk);
        #1;
        chk("done_pulse_width", 64'(done), 64'd0);
    endtask

    initial begin
        logic [31:0] op;
        logic [9:0]  dpat;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        saw_done;

        tbl[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
        tbl[1] = '{32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[2] = '{32'h1234_0000, 32'hEDCC_0000, 1'b0};
        tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
        tbl[4] = '{32'h8000_0000, 32'h8000_0000, 1'b1};
        tbl[5] = '{32'h7FFF_FFFF, 32'h8000_0001, 1'b0};

        rst = 1'b1; start = 1'b0; operand = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_carry", 64'(dut.carry_q), 64'd1);
`ifdef TC_OVF_EN
        chk("reset_ovf", 64'(ovf), 64'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].op, tbl[i].res, tbl[i].ovf);
        end

        // Zero operand: the +1 carry must survive every byte.
        @(negedge clk);
        start = 1'b1; operand = 32'h0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < NB; i++) begin
            chk("carry_probe", 64'(dut.carry_q), 64'd1);
            @(posedge clk);
            #1;
        end
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_result", 64'(result), 64'd0);
        @(posedge clk);

        // start held for 10 cycles: operand change during RUN must be ignored.
        @(negedge clk);
        start = 1'b1; operand = 32'h0000_0001;
        dpat = '0; ra = '0; rb = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) operand = 32'h1234_5678;
            dpat[i] = done;
            if (i == 4) ra = result;
            if (i == 9) rb = result;
        end
        start = 1'b0;
        chk("b2b_done_pattern", 64'(dpat), 64'(10'b10_0001_0000));
        chk("b2b_first", 64'(ra), 64'(model_neg(32'h0000_0001)));
        chk("b2b_second", 64'(rb), 64'(model_neg(32'h1234_5678)));
        @(posedge clk);
        #1;
        chk("b2b_idle_done", 64'(done), 64'd0);
        chk("b2b_idle_busy", 64'(busy), 64'd0);

        // Reset after two bytes have been processed.
        @(negedge clk);
        start = 1'b1; operand = 32'h1122_3344;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("midrst_no_done", 64'(saw_done), 64'd0);
        run_op(32'h1122_3344, 32'hEEDD_CCBC, 1'b0);

        for (int i = 0; i < 24; i++) begin
            case (i % 4)
                0: op = $urandom;
                1: op = {8'($urandom), 24'h0};
                2: op = {16'($urandom), 16'h0};
                default: op = 32'($urandom_range(0, 3));
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
            run_op(op, model_neg(op), op == 32'h8000_0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
